// File: rtl/mac_requant.sv
// mac_requant: output requantization stage between the MAC engine and the
// streamer sink.
//
// Each 32-bit signed MAC result gets a per-job bias added. It is then shifted
// right arithmetically, with optional round-to-nearest. An optional ReLU is
// applied, and the value is saturated to OUT_BITS signed. Results leave through
// a 2-stage elastic pipeline, sign-extended to 32 bits. A small controller
// counts `len` output handshakes per job and reports done/sat to the
// controller.
//
// Contents of this file:
//   mac_requant_pkg       control / flag structs (counter width lives here)
//   mac_requant_stream_if 32-bit HWPE-Stream style valid/ready interface
//   mac_requant           the datapath and controller
//
// Ports of mac_requant:
//   clk_i        in   clock
//   rst_ni       in   synchronous active-low reset
//   test_mode_i  in   unused functionally
//   d_i          sink   MAC results (signed 32-bit)
//   q_o          source requantized results, strb always all-ones
//   ctrl_i       in   clear/enable/start, len, bias, shift, round, relu
//   flags_o      out  cnt, done, sat, state (state doubles as FSM debug view)
//
// Handshake semantics, used on every stream in this file:
// a transfer happens on a rising clk edge where valid and ready are both 1.
// A source keeps valid high and data stable until that transfer occurs.
// valid never depends combinationally on ready. ready may depend on the
// downstream ready.

package mac_requant_pkg;

  // Job length / output counter width. The control and flag structs are
  // sized from it, so change it here rather than per instance.
  localparam int unsigned CNT_WIDTH = 16;

  typedef struct packed {
    logic                 clear;
    logic                 enable;
    logic                 start;
    logic [CNT_WIDTH-1:0] len;
    logic [31:0]          bias;
    logic [4:0]           shift;
    logic                 round;
    logic                 relu;
  } ctrl_t;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] cnt;
    logic                 done;
    logic                 sat;
    logic [1:0]           state;
  } flags_t;

endpackage

interface mac_requant_stream_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic [3:0]  strb;

  modport sink   (input  valid, data, strb, output ready);
  modport source (output valid, data, strb, input  ready);
endinterface

module mac_requant #(
  parameter int unsigned OUT_BITS = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  mac_requant_stream_if.sink      d_i,
  mac_requant_stream_if.source    q_o,
  input  mac_requant_pkg::ctrl_t  ctrl_i,
  output mac_requant_pkg::flags_t flags_o
);

  localparam int unsigned CW = mac_requant_pkg::CNT_WIDTH;

  // FSM encoding, visible on flags_o.state
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Saturation bounds in the 34-bit stage-1 domain and the OUT_BITS domain
  localparam logic signed [33:0] SAT_MAX = (34'sd1 <<< (OUT_BITS - 1)) - 34'sd1;
  localparam logic signed [33:0] SAT_MIN = -(34'sd1 <<< (OUT_BITS - 1));
  localparam logic signed [OUT_BITS-1:0] OUT_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [OUT_BITS-1:0] OUT_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]                 state_q;
  logic [CW-1:0]              cnt_q;     // output handshakes this job
  logic [CW-1:0]              in_cnt_q;  // input handshakes this job
  logic                       done_q;
  logic                       sat_q;

  logic signed [33:0]         s1_q;
  logic                       s1_valid_q;
  logic signed [OUT_BITS-1:0] s2_q;
  logic                       s2_valid_q;

  // ---------------------------------------------------------------------------
  // Handshake network
  // ---------------------------------------------------------------------------
  logic en;
  logic q_valid;
  logic q_hs;
  logic s2_ready;
  logic s1_ready;
  logic in_room;
  logic d_ready;
  logic d_hs;
  logic s12_hs;

  assign en       = ctrl_i.enable;
  assign q_valid  = en & s2_valid_q;
  assign q_hs     = q_valid & q_o.ready;
  assign s2_ready = ~s2_valid_q | q_o.ready;
  assign s1_ready = ~s1_valid_q | s2_ready;

  // A job never takes more than len inputs, so the pipeline cannot hold items
  // that belong to no output slot.
  assign in_room  = (in_cnt_q < ctrl_i.len);

  // clear wipes stage 1 this edge. Refusing input during clear keeps an
  // upstream transfer from being silently dropped.
  assign d_ready  = en & ~ctrl_i.clear & (state_q == ST_RUN) & s1_ready & in_room;
  assign d_hs     = d_i.valid & d_ready;
  assign s12_hs   = en & s1_valid_q & s2_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 arithmetic: bias, rounding offset, arithmetic shift
  // ---------------------------------------------------------------------------
  logic signed [33:0] d_ext;
  logic signed [33:0] bias_ext;
  logic signed [33:0] rnd;
  logic signed [33:0] sum;
  logic signed [33:0] s1_next;

  always_comb begin
    d_ext    = {{2{d_i.data[31]}}, d_i.data};
    bias_ext = {{2{ctrl_i.bias[31]}}, ctrl_i.bias};
    rnd      = '0;
    if (ctrl_i.round && (ctrl_i.shift != 5'd0)) begin
      rnd = 34'sd1 <<< (ctrl_i.shift - 5'd1);
    end
    // 34 bits cover two full-range 32-bit operands plus the rounding offset
    sum     = d_ext + bias_ext + rnd;
    s1_next = sum >>> ctrl_i.shift;
  end

  // ---------------------------------------------------------------------------
  // Stage 2 arithmetic: ReLU and saturation
  // ---------------------------------------------------------------------------
  logic                       relu_zero;
  logic                       over;
  logic                       under;
  logic                       sat_hit;
  logic signed [OUT_BITS-1:0] s2_next;

  always_comb begin
    relu_zero = ctrl_i.relu & s1_q[33];
    over      = (s1_q > SAT_MAX);
    under     = (s1_q < SAT_MIN);
    // ReLU clamping to zero is intentional and is not reported as saturation
    sat_hit   = ~relu_zero & (over | under);
    if (relu_zero) begin
      s2_next = '0;
    end else if (over) begin
      s2_next = OUT_MAX;
    end else if (under) begin
      s2_next = OUT_MIN;
    end else begin
      s2_next = s1_q[OUT_BITS-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential: pipeline registers and job controller
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_inc;
  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_cnt_q   <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
    end else if (ctrl_i.clear) begin
      // clear beats a coincident final output handshake, so done stays low
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_cnt_q   <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
    end else if (en) begin
      // Stage 1: loads on input transfer, empties on transfer into stage 2
      if (d_hs) begin
        s1_q <= s1_next;
      end
      if (d_hs) begin
        s1_valid_q <= 1'b1;
      end else if (s12_hs) begin
        s1_valid_q <= 1'b0;
      end

      // Stage 2: loads on stage-1 transfer, empties on output transfer
      if (s12_hs) begin
        s2_q <= s2_next;
      end
      if (s12_hs) begin
        s2_valid_q <= 1'b1;
      end else if (q_hs) begin
        s2_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (ctrl_i.start) begin
            cnt_q    <= '0;
            in_cnt_q <= '0;
            sat_q    <= 1'b0;
            if (ctrl_i.len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              done_q  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          // start is ignored while a job is running
          if (d_hs) begin
            in_cnt_q <= in_cnt_q + CW'(1);
          end
          if (s12_hs && sat_hit) begin
            sat_q <= 1'b1;
          end
          if (q_hs) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == ctrl_i.len) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign d_i.ready = d_ready;
  assign q_o.valid = q_valid;
  assign q_o.data  = 32'(s2_q);  // s2_q is signed, so the cast sign-extends
  assign q_o.strb  = '1;

  always_comb begin
    flags_o       = '0;
    flags_o.cnt   = cnt_q;
    flags_o.done  = done_q;
    flags_o.sat   = sat_q;
    flags_o.state = state_q;
  end

  logic unused_inputs;
  assign unused_inputs = ^{test_mode_i, d_i.strb};

endmodule

// File: tb/tb_mac_requant.sv
// Testbench for mac_requant (OUT_BITS = 16).
// The directed jobs carry hand-derived expected values. The random jobs are
// scored against a plain-integer reference model of the requantization rules.

module tb_mac_requant;
  import mac_requant_pkg::*;

  localparam int OUT_BITS = 16;
  // state codes in the order IDLE, RUN, DONE
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic   clk = 1'b0;
  logic   rst_ni = 1'b0;
  logic   test_mode = 1'b0;
  ctrl_t  ctrl;
  flags_t flags;

  mac_requant_stream_if d_if ();
  mac_requant_stream_if q_if ();

  mac_requant #(.OUT_BITS(OUT_BITS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .test_mode_i (test_mode),
    .d_i         (d_if),
    .q_o         (q_if),
    .ctrl_i      (ctrl),
    .flags_o     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];
  bit          model_sat;

  // Reference: exact integer arithmetic on 64-bit values, then clamp.
  function automatic logic [31:0] model(input logic [31:0] d);
    longint v, hi, lo;
    hi = (longint'(1) << (OUT_BITS - 1)) - 1;
    lo = -hi - 1;
    v  = longint'($signed(d)) + longint'($signed(ctrl.bias));
    if (ctrl.round && ctrl.shift != 0) v = v + (longint'(1) << (ctrl.shift - 1));
    v = v >>> ctrl.shift;  // floor(v / 2**shift)
    if (ctrl.relu && v < 0) v = 0;
    else if (v > hi) begin v = hi; model_sat = 1'b1; end
    else if (v < lo) begin v = lo; model_sat = 1'b1; end
    return v[31:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_qvalid"}, q_if.valid, 0);
    check({tag, "_qdata"},  q_if.data, 0);
    check({tag, "_dready"}, d_if.ready, 0);
    check({tag, "_flags"},  64'(flags), 0);
  endtask

  task automatic start_job(input int len, input logic [31:0] bias, input int shift,
                           input bit rnd, input bit relu);
    @(negedge clk);
    ctrl.len   = CNT_WIDTH'(len);
    ctrl.bias  = bias;
    ctrl.shift = 5'(shift);
    ctrl.round = rnd;
    ctrl.relu  = relu;
    ctrl.start = 1'b1;
    d_if.valid = 1'b0;
    q_if.ready = 1'b1;
    @(negedge clk);
    ctrl.start = 1'b0;
    model_sat  = 1'b0;
    #1;
    check("start_state", flags.state, (len == 0) ? S_DONE : S_RUN);
  endtask

  // Streams one job: offers in_q (then junk) with random valid, random ready
  // after `stall` forced-low cycles, and scores every output transfer.
  task automatic run_stream(input int n_out, input int n_acc, input int p_valid,
                            input int p_ready, input int stall, input bit use_model,
                            input bit exp_sat, output int stall_acc, output int first_acc,
                            output int first_out, output int last_out);
    int          acc, outs, budget;
    bit          was_stalled;
    logic [31:0] held, v;
    logic [63:0] exp_v;
    acc = 0; outs = 0; budget = 0; was_stalled = 0; held = '0;
    stall_acc = 0; first_acc = -1; first_out = -1; last_out = -1;
    while (outs < n_out && budget < 2000) begin
      @(negedge clk);
      budget++;
      d_if.valid = ($urandom_range(99) < p_valid);
      d_if.data  = (in_q.size() != 0) ? in_q[0] : $urandom;
      q_if.ready = (budget > stall) && ($urandom_range(99) < p_ready);
      #1;
      if (was_stalled) begin
        check("hold_valid", q_if.valid, 1);
        check("hold_data", q_if.data, held);
      end
      if (d_if.valid && d_if.ready) begin
        acc++;
        if (budget <= stall) stall_acc++;
        if (first_acc < 0) first_acc = budget;
        if (in_q.size() != 0) begin
          v = in_q.pop_front();
          if (use_model) exp_q.push_back(model(v));
        end
      end
      if (q_if.valid && q_if.ready) begin
        outs++;
        if (first_out < 0) first_out = budget;
        last_out = budget;
        if (exp_q.size() != 0) exp_v = {32'd0, exp_q.pop_front()};
        else exp_v = 64'hx;
        check("q_data", {32'd0, q_if.data}, exp_v);
      end
      was_stalled = q_if.valid && !q_if.ready;
      held        = q_if.data;
    end
    check("n_out", outs, n_out);
    check("n_accepted", acc, n_acc);
    @(negedge clk);
    d_if.valid = 1'b0;
    q_if.ready = 1'b1;
    #1;
    check("job_done", flags.done, 1);
    check("job_cnt", flags.cnt, n_out);
    check("job_state", flags.state, S_DONE);
    check("job_sat", flags.sat, use_model ? model_sat : exp_sat);
    check("job_qvalid", q_if.valid, 0);
    check("job_exp_left", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int sa, fa, fo, lo, len, shift;
    logic [31:0] bias, dv;
    bit ready_seen;

    ctrl        = '0;
    ctrl.enable = 1'b1;
    d_if.valid  = 1'b1;
    d_if.data   = 32'd5;
    d_if.strb   = '1;
    q_if.ready  = 1'b1;

    // reset
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_ni     = 1'b1;
    d_if.valid = 1'b0;

    // basic pass-through, latency and throughput
    start_job(4, 32'd0, 0, 0, 0);
    in_q  = {32'd1, 32'd2, 32'd3, 32'd4};
    exp_q = {32'd1, 32'd2, 32'd3, 32'd4};
    run_stream(4, 4, 100, 100, 0, 0, 0, sa, fa, fo, lo);
    check("basic_latency", fo - fa, 2);
    check("basic_tput", lo - fo, 3);

    // saturation
    start_job(3, 32'd0, 0, 0, 0);
    in_q  = {32'd65536, 32'(-70000), 32'd32767};
    exp_q = {32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_7FFF};
    run_stream(3, 3, 100, 100, 0, 0, 1, sa, fa, fo, lo);
    start_job(1, 32'(-65536), 0, 0, 0);
    in_q  = {32'd65540};
    exp_q = {32'd4};
    run_stream(1, 1, 100, 100, 0, 0, 0, sa, fa, fo, lo);

    // rounding
    start_job(2, 32'd0, 2, 1, 0);
    in_q  = {32'd7, 32'(-7)};
    exp_q = {32'd2, 32'hFFFF_FFFE};
    run_stream(2, 2, 100, 100, 0, 0, 0, sa, fa, fo, lo);
    start_job(1, 32'd0, 2, 0, 0);
    in_q  = {32'd7};
    exp_q = {32'd1};
    run_stream(1, 1, 100, 100, 0, 0, 0, sa, fa, fo, lo);
    start_job(1, 32'd0, 0, 1, 0);
    in_q  = {32'd5};
    exp_q = {32'd5};
    run_stream(1, 1, 100, 100, 0, 0, 0, sa, fa, fo, lo);

    // ReLU is not saturation
    start_job(2, 32'd0, 0, 0, 1);
    in_q  = {32'(-5), 32'(-100000)};
    exp_q = {32'd0, 32'd0};
    run_stream(2, 2, 100, 100, 0, 0, 0, sa, fa, fo, lo);

    // backpressure: 6 stalled cycles, exactly 2 absorbed
    start_job(4, 32'd0, 0, 0, 0);
    in_q  = {32'd10, 32'd20, 32'd30, 32'd40};
    exp_q = {32'd10, 32'd20, 32'd30, 32'd40};
    run_stream(4, 4, 100, 100, 6, 0, 0, sa, fa, fo, lo);
    check("bp_stall_accepts", sa, 2);

    // enable low holds everything and masks the handshake signals
    start_job(3, 32'd0, 0, 0, 0);
    in_q  = {32'd100, 32'd200, 32'd300};
    exp_q = {32'd100, 32'd200, 32'd300};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      q_if.ready = 1'b0;
      d_if.valid = 1'b1;
      d_if.data  = in_q[0];
      #1;
      if (d_if.ready) void'(in_q.pop_front());
    end
    @(negedge clk);
    ctrl.enable = 1'b0;
    q_if.ready  = 1'b1;
    d_if.data   = in_q[0];
    #1;
    check("en_qvalid", q_if.valid, 0);
    check("en_dready", d_if.ready, 0);
    @(negedge clk);
    #1;
    check("en_hold_state", flags.state, S_RUN);
    check("en_hold_cnt", flags.cnt, 0);
    @(negedge clk);
    ctrl.enable = 1'b1;
    q_if.ready  = 1'b0;
    #1;
    check("en_resume_valid", q_if.valid, 1);
    check("en_resume_data", q_if.data, 32'd100);
    run_stream(3, 1, 100, 100, 0, 0, 0, sa, fa, fo, lo);

    // clear with both stages full
    start_job(4, 32'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      q_if.ready = 1'b0;
      d_if.valid = 1'b1;
      d_if.data  = 32'(i + 50);
      #1;
    end
    check("full_dready_low", d_if.ready, 0);
    check("full_qvalid", q_if.valid, 1);
    @(negedge clk);
    ctrl.clear = 1'b1;
    @(negedge clk);
    ctrl.clear = 1'b0;
    d_if.valid = 1'b0;
    #1;
    check("clr_qvalid", q_if.valid, 0);
    check("clr_state", flags.state, S_IDLE);
    check("clr_cnt", flags.cnt, 0);
    check("clr_dready", d_if.ready, 0);

    // clear coincident with the final output handshake
    start_job(1, 32'd0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d_if.valid = 1'b1;
      d_if.data  = 32'd77;
      q_if.ready = 1'b0;
      #1;
      if (q_if.valid) break;
    end
    check("cf_valid", q_if.valid, 1);
    check("cf_data", q_if.data, 32'd77);
    q_if.ready = 1'b1;
    ctrl.clear = 1'b1;
    d_if.valid = 1'b0;
    @(negedge clk);
    ctrl.clear = 1'b0;
    #1;
    check("cf_done", flags.done, 0);
    check("cf_state", flags.state, S_IDLE);
    check("cf_qvalid", q_if.valid, 0);

    // len = 0 goes straight to DONE and never accepts
    @(negedge clk);
    ctrl.len   = '0;
    ctrl.start = 1'b1;
    d_if.valid = 1'b1;
    #1;
    ready_seen = d_if.ready;
    @(negedge clk);
    ctrl.start = 1'b0;
    #1;
    check("len0_state", flags.state, S_DONE);
    check("len0_done", flags.done, 1);
    check("len0_cnt", flags.cnt, 0);
    repeat (4) begin
      @(negedge clk);
      #1;
      ready_seen |= d_if.ready;
    end
    check("len0_dready", ready_seen, 0);
    d_if.valid = 1'b0;

    // random jobs against the reference model
    for (int j = 0; j < 10; j++) begin
      len = $urandom_range(1, 24);
      case ($urandom_range(0, 2))
        0:       bias = 32'd0;
        1:       bias = $urandom_range(0, 2000) - 1000;
        default: bias = $urandom;
      endcase
      shift = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4) : $urandom_range(0, 31);
      start_job(len, bias, shift, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 2))
          0:       dv = $urandom_range(0, 2000) - 1000;
          1:       dv = $urandom_range(0, 200000) - 100000;
          default: dv = $urandom;
        endcase
        in_q.push_back(dv);
      end
      run_stream(len, len, $urandom_range(50, 100), $urandom_range(30, 100),
                 $urandom_range(0, 3), 1, 0, sa, fa, fo, lo);
    end

    // reset in the middle of a job
    start_job(8, 32'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      q_if.ready = 1'b0;
      d_if.valid = 1'b1;
      d_if.data  = 32'(i + 1000);
    end
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    #1;
    check_reset_vals("midrst");
    rst_ni = 1'b1;
    in_q.delete();
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
